// File: rtl/can_crc_stuff.sv
// CAN FD transmit CRC-field fixed-stuff-bit inserter: serialises a latched 17/21-bit CRC
// MSB first with a complementing stuff bit at every field position that is a multiple of 5.
module can_crc_stuff (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        crc_21_sel,
    input  logic [16:0] crc_17_i,
    input  logic [20:0] crc_21_i,
    input  logic        data_prev,
    input  logic        tx_point,
    input  logic        abort,
    output logic        tx_bit,
    output logic        tx_is_stuff,
    output logic        busy,
    output logic        done,
    output logic [8:0]  bit_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    logic [1:0]  state_q,       state_d;
    logic [20:0] sr_q,          sr_d;
    logic        sel_q,         sel_d;
    logic        tx_bit_q,      tx_bit_d;
    logic        tx_is_stuff_q, tx_is_stuff_d;
    logic [8:0]  bit_cnt_q,     bit_cnt_d;
    logic [2:0]  phase_q,       phase_d;
    logic [8:0]  last_cnt;

    // Last field index: N-1 = 21 for CRC-17, 26 for CRC-21.
    assign last_cnt = sel_q ? 9'd26 : 9'd21;

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        sel_d         = sel_q;
        tx_bit_d      = tx_bit_q;
        tx_is_stuff_d = tx_is_stuff_q;
        bit_cnt_d     = bit_cnt_q;
        phase_d       = phase_q;

        case (state_q)
            S_IDLE: begin
                if (!abort && start) begin
                    state_d       = S_SEND;
                    sel_d         = crc_21_sel;
                    sr_d          = crc_21_sel ? crc_21_i : {crc_17_i, 4'b0000};
                    tx_bit_d      = ~data_prev;
                    tx_is_stuff_d = 1'b1;
                    bit_cnt_d     = 9'd0;
                    phase_d       = 3'd0;
                end
            end
            S_SEND: begin
                if (abort) begin
                    state_d       = S_IDLE;
                    tx_bit_d      = 1'b1;
                    tx_is_stuff_d = 1'b0;
                    bit_cnt_d     = 9'd0;
                    phase_d       = 3'd0;
                end else if (tx_point) begin
                    if (bit_cnt_q == last_cnt) begin
                        state_d = S_FIN;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 9'd1;
                        phase_d   = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
                        // Only a completed payload bit consumes the shift register.
                        if (!tx_is_stuff_q) begin
                            sr_d = {sr_q[19:0], 1'b0};
                        end
                        if (phase_q == 3'd4) begin
                            tx_bit_d      = ~tx_bit_q;
                            tx_is_stuff_d = 1'b1;
                        end else begin
                            tx_bit_d      = sr_d[20];
                            tx_is_stuff_d = 1'b0;
                        end
                    end
                end
            end
            S_FIN: begin
                state_d       = S_IDLE;
                tx_bit_d      = 1'b1;
                tx_is_stuff_d = 1'b0;
                bit_cnt_d     = 9'd0;
                phase_d       = 3'd0;
            end
            default: begin
                state_d       = S_IDLE;
                tx_bit_d      = 1'b1;
                tx_is_stuff_d = 1'b0;
                bit_cnt_d     = 9'd0;
                phase_d       = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sr_q          <= '0;
            sel_q         <= 1'b0;
            tx_bit_q      <= 1'b1;
            tx_is_stuff_q <= 1'b0;
            bit_cnt_q     <= 9'd0;
            phase_q       <= 3'd0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            sel_q         <= sel_d;
            tx_bit_q      <= tx_bit_d;
            tx_is_stuff_q <= tx_is_stuff_d;
            bit_cnt_q     <= bit_cnt_d;
            phase_q       <= phase_d;
        end
    end

    assign tx_bit      = tx_bit_q;
    assign tx_is_stuff = tx_is_stuff_q;
    assign bit_cnt     = bit_cnt_q;
    assign busy        = (state_q == S_SEND);
    assign done        = (state_q == S_FIN);

endmodule
